// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// controller state encoding and default parameter values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } pipe_state_e;

    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with an asynchronous active-low clear.
// The count sticks at all-ones and never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: same-cycle advance/stall/flush/freeze
// decision, memory-wait timeout tracking and saturating perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    pipe_state_e       state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next, wait_inc;
    logic              err_reg;

    logic load_use, br_taken, mem_busy, decide;
    logic pc_write_c, pc_src_c, ifid_write_c, ifid_flush_c;
    logic idex_flush_c, exmem_flush_c, pipe_en_c;

    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign br_taken = exmem_branch && exmem_zero;
    assign mem_busy = (exmem_mem_read || exmem_mem_write) && !dmem_ready;
    assign wait_inc = wait_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        wait_next     = wait_reg;
        decide        = 1'b0;
        pc_write_c    = 1'b0;
        pc_src_c      = 1'b0;
        ifid_write_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        pipe_en_c     = 1'b0;

        unique case (state_reg)
            RUN: begin
                if (mem_busy) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    decide = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    // Timeout bounds the total number of freeze cycles.
                    if (wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
                        state_next = ERR;
                    end else begin
                        wait_next = wait_inc;
                    end
                end else begin
                    decide     = 1'b1;
                    state_next = RUN;
                    wait_next  = '0;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase

        if (decide) begin
            if (br_taken) begin
                pc_src_c      = 1'b1;
                pc_write_c    = 1'b1;
                ifid_write_c  = 1'b1;
                pipe_en_c     = 1'b1;
                ifid_flush_c  = 1'b1;
                idex_flush_c  = 1'b1;
                exmem_flush_c = 1'b1;
            end else if (load_use) begin
                // Load moves on to EX/MEM, so a single bubble clears the hazard.
                idex_flush_c = 1'b1;
                pipe_en_c    = 1'b1;
            end else begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
                pipe_en_c    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            wait_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            err_reg   <= err_reg || (state_next == ERR);
        end
    end

    // Strobes are forced low for the whole reset, independent of clk.
    assign pc_write        = pc_write_c    && rst_n;
    assign pc_src          = pc_src_c      && rst_n;
    assign ifid_write      = ifid_write_c  && rst_n;
    assign ifid_flush      = ifid_flush_c  && rst_n;
    assign idex_flush      = idex_flush_c  && rst_n;
    assign exmem_flush     = exmem_flush_c && rst_n;
    assign pipe_en         = pipe_en_c     && rst_n;
    assign mem_timeout_err = err_reg;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write_c),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_src_c),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a behavioural model
// of the advance/stall/flush/freeze rules, plus short directed sequences.
module tb_pipeline_hazard_ctrl;

    localparam int T     = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    ifid_rs, ifid_rt, idex_rt;
    logic          ifid_uses_rt, idex_mem_read;
    logic          exmem_branch, exmem_zero, exmem_mem_read, exmem_mem_write, dmem_ready;
    logic          pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_timeout_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: freeze cycles spent in the current memory wait (0 = none), error, counters
    int m_wait  = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .ifid_uses_rt    (ifid_uses_rt),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .exmem_branch    (exmem_branch),
        .exmem_zero      (exmem_zero),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .pipe_en         (pipe_en),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout_err (mem_timeout_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en};
    endfunction

    task automatic check_regs();
        check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check_val("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        check_val("mem_timeout_err", 32'(mem_timeout_err), 32'(m_err));
    endtask

    // Called at posedge+1: apply inputs, check mid-cycle, advance model over the edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic imr, input logic [4:0] irt, input logic br, input logic z,
                        input logic mr, input logic mw, input logic rdy);
        bit lu, bt, busy, freeze;
        logic [6:0] exp;
        ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt; idex_mem_read = imr; idex_rt = irt;
        exmem_branch = br; exmem_zero = z; exmem_mem_read = mr; exmem_mem_write = mw;
        dmem_ready = rdy;
        lu     = imr && (irt != 0) && ((irt == rs) || (urt && (irt == rt)));
        bt     = br && z;
        busy   = (mr || mw) && !rdy;
        freeze = m_err || ((m_wait > 0) ? !rdy : busy);
        // bit order: pc_write pc_src ifid_write ifid_flush idex_flush exmem_flush pipe_en
        if (freeze)   exp = 7'b0000000;
        else if (bt)  exp = 7'b1111111;
        else if (lu)  exp = 7'b0000101;
        else          exp = 7'b1010001;
        #3;
        check_val("strobes", 32'(strobes()), 32'(exp));
        check_regs();
        $display("[%0t] in mr=%b mw=%b rdy=%b br=%b lu=%b | strb=%b stall=%0d flush=%0d err=%b",
                 $time, mr, mw, rdy, bt, lu, strobes(), stall_cnt, flush_cnt, mem_timeout_err);
        @(posedge clk);
        if (!exp[6] && m_stall < CMAX) m_stall++;
        if (exp[5] && m_flush < CMAX) m_flush++;
        if (!m_err) begin
            if (!freeze) m_wait = 0;
            else if (m_wait == 0) m_wait = 1;
            else begin
                m_wait++;
                if (m_wait >= T) m_err = 1'b1;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse with hazard-provoking inputs still applied.
    task automatic do_reset();
        ifid_rs = 5'd3; idex_rt = 5'd3; idex_mem_read = 1'b1;
        exmem_branch = 1'b1; exmem_zero = 1'b1; exmem_mem_read = 1'b1; dmem_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        check_val("rst_strobes", 32'(strobes()), 32'd0);
        check_regs();
        $display("[%0t] reset asserted strb=%b stall=%0d flush=%0d err=%b",
                 $time, strobes(), stall_cnt, flush_cnt, mem_timeout_err);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int thr;
        rst_n = 1'b0;
        ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; idex_mem_read = 1'b0; idex_rt = '0;
        exmem_branch = 1'b0; exmem_zero = 1'b0; exmem_mem_read = 1'b0; exmem_mem_write = 1'b0;
        dmem_ready = 1'b1;
        #8;
        check_val("rst_strobes", 32'(strobes()), 32'd0);
        check_regs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use, then hazard gone
        step(5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(5'd8, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Register zero never stalls
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Hazard via rt
        step(5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Branch alone, then branch beating load-use
        step(5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        // Memory wait: three cycles low, released on the fourth
        for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Timeout and sticky error, cleared by reset
        for (int i = 0; i < 7; i++) step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        do_reset();
        // Saturation of stall_cnt with a persistent load-use
        for (int i = 0; i < 20; i++) step(5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Saturation of flush_cnt
        for (int i = 0; i < 18; i++) step(5'd5, 5'd1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();

        // Random blocks with varying memory latency behaviour
        for (int blk = 0; blk < 20; blk++) begin
            thr = (blk % 3 == 0) ? 9 : ((blk % 3 == 1) ? 5 : 1);
            for (int i = 0; i < 30; i++) begin
                step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 9) < thr));
            end
            if ($urandom_range(0, 1) == 0 || m_err) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
